fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: fetch-PC generator plus DEPTH-entry {PC, instr} circular queue feeding decode; build option FETCH_QUEUE_BYPASS_EN.
// Latency: valid_o one cycle after a push into an empty queue; zero cycles with FETCH_QUEUE_BYPASS_EN while empty.
// Backpressure: ready_i low fills the queue, then the fetch PC and entries hold; redirect_i flushes and re-steers.
module fetch_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [DATA_WIDTH-1:0]         imem_addr_o,
    input  logic [DATA_WIDTH-1:0]         imem_rdata_i,
    input  logic                          redirect_i,
    input  logic [DATA_WIDTH-1:0]         redirect_pc_i,
    input  logic                          ready_i,
    output logic                          valid_o,
    output logic [DATA_WIDTH-1:0]         Instr_o,
    output logic [DATA_WIDTH-1:0]         PC_o,
    output logic [DATA_WIDTH-1:0]         PCPlus4_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    entry_t                mem [DEPTH];
    entry_t                head;
    logic [DATA_WIDTH-1:0] fetchPc;
    logic [PW-1:0]         rdPtr;
    logic [PW-1:0]         wrPtr;
    logic [CW-1:0]         count;
    logic                  empty;
    logic                  pop;
    logic                  push;
    logic                  writeEn;

    always_comb begin
        empty = (count == '0);
        head  = mem[rdPtr];
`ifdef FETCH_QUEUE_BYPASS_EN
        valid_o = ~redirect_i;
        // Empty queue: present the word being fetched right now.
        if (empty) begin
            head = {fetchPc, imem_rdata_i};
        end
`else
        valid_o = ~empty & ~redirect_i;
`endif
        pop  = ~empty & valid_o & ready_i;
        push = ~redirect_i & ((count < CW'(DEPTH)) | pop);
`ifdef FETCH_QUEUE_BYPASS_EN
        // A bypassed word taken by decode advances the PC but never lands in storage.
        writeEn = push & ~(empty & ready_i);
`else
        writeEn = push;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc <= RESET_PC;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else if (redirect_i) begin
            fetchPc <= redirect_pc_i;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                fetchPc <= fetchPc + DATA_WIDTH'(4);
            end
            if (writeEn) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({writeEn, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset; count/pointers define what is live.
    always_ff @(posedge clk) begin
        if (writeEn && !rst) begin
            mem[wrPtr] <= {fetchPc, imem_rdata_i};
        end
    end

    assign imem_addr_o = fetchPc;
    assign Instr_o     = head.instr;
    assign PC_o        = head.pc;
    assign PCPlus4_o   = head.pc + DATA_WIDTH'(4);
    assign count_o     = count;

endmodule
